// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding and period/high-time/timeout helpers for blink receivers.
package blink_pkg;

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    function automatic int blink_period(input int tap);
        return 1 << (tap + 1);
    endfunction

    function automatic int blink_high(input int tap);
        return 1 << tap;
    endfunction

    function automatic int blink_timeout(input int tap);
        return 2 * blink_period(tap);
    endfunction

endpackage

// File: rtl/blink_sync_edge.sv
// blink_sync_edge: multi-flop synchronizer for an asynchronous line with registered rise/fall detection.
module blink_sync_edge
    import blink_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic s_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            s_prev <= 1'b0;
        end else begin
            sr     <= {sr[STAGES-2:0], din};
            s_prev <= sr[STAGES-1];
        end
    end

    assign sync = sr[STAGES-1];
    assign rise = sync & ~s_prev;
    assign fall = ~sync & s_prev;

endmodule

// File: rtl/blink_phase_decoder.sv
// blink_phase_decoder: recovers the low offset bits and period of a remote blinker
// sharing current_count, and flags lock once the phase has been stable for several periods.
module blink_phase_decoder
    import blink_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int TAP         = 9,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_EDGES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blink_in,
    input  logic [COUNT_W-1:0] current_count,
    output logic [COUNT_W-1:0] offset_out,
    output logic               offset_valid,
    output logic [COUNT_W-1:0] period_out,
    output logic               err
);

    localparam int MW = $clog2(LOCK_EDGES + 1);
    localparam logic [COUNT_W-1:0] P_W    = COUNT_W'(blink_period(TAP));
    localparam logic [COUNT_W-1:0] H_W    = COUNT_W'(blink_high(TAP));
    localparam logic [COUNT_W:0]   TO_W   = (COUNT_W+1)'(blink_timeout(TAP));
    localparam logic [COUNT_W-1:0] BASE_W = COUNT_W'(blink_high(TAP) + SYNC_STAGES);
    localparam logic [MW-1:0]      LAST_M = MW'(LOCK_EDGES - 1);

    logic sync, rise, fall;
    logic [COUNT_W-1:0] per_cnt, per_inc, hi_cnt, hi_cap, phase_reg, cand;
    logic [MW-1:0] match_cnt;
    logic match, timeout, take, bump, lock, err_n;
    state_t state, state_n;

    blink_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .din (blink_in),
        .sync(sync),
        .rise(rise),
        .fall(fall)
    );

    // The rise is seen SYNC_STAGES cycles late, so that latency is folded into the estimate.
    assign cand    = (BASE_W - current_count) & (P_W - 1'b1);
    assign per_inc = &per_cnt ? per_cnt : per_cnt + 1'b1;
    assign match   = (per_inc == P_W) && (hi_cap == H_W) && (cand == phase_reg);
    assign timeout = {1'b0, per_cnt} >= TO_W;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        bump    = 1'b0;
        lock    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                state_n = rise ? MEASURE : IDLE;
                take    = rise;
            end
            MEASURE: begin
                if (rise) begin
                    bump    = match;
                    take    = !match;
                    lock    = match && (match_cnt == LAST_M);
                    state_n = lock ? LOCKED : MEASURE;
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            LOCKED: begin
                if (rise) begin
                    take    = !match;
                    err_n   = !match;
                    state_n = match ? LOCKED : MEASURE;
                end else if (timeout) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            hi_cnt       <= '0;
            hi_cap       <= '0;
            phase_reg    <= '0;
            match_cnt    <= '0;
            offset_out   <= '0;
            offset_valid <= 1'b0;
            period_out   <= '0;
            err          <= 1'b0;
        end else begin
            per_cnt      <= rise ? '0 : per_inc;
            hi_cnt       <= rise ? COUNT_W'(1) : (sync && !(&hi_cnt)) ? hi_cnt + 1'b1 : hi_cnt;
            hi_cap       <= fall ? hi_cnt : hi_cap;
            phase_reg    <= take ? cand : phase_reg;
            match_cnt    <= take ? '0 : bump ? match_cnt + 1'b1 : match_cnt;
            offset_out   <= lock ? phase_reg : offset_out;
            offset_valid <= state_n == LOCKED;
            period_out   <= (rise && state != IDLE) ? per_inc : period_out;
            err          <= err_n;
        end
    end

endmodule

// File: tb/tb_blink_phase_decoder.sv
// tb_blink_phase_decoder: directed bench driving a blinker model against the phase decoder.
module tb_blink_phase_decoder;

    localparam int P = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic blink_in = 1'b0;
    logic [15:0] cnt = '0;
    logic [15:0] offset_out, period_out;
    logic offset_valid, err;

    logic [15:0] off = '0;
    logic en = 1'b0, duty = 1'b0, stuck = 1'b0, rose = 1'b0;
    int total = 0, bad = 0, err_seen = 0, valid_seen = 0;

    typedef struct {
        logic [15:0] off;
        bit          duty;
        logic [15:0] exp_off;
        logic [15:0] exp_per;
        bit          exp_lock;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    blink_phase_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .blink_in     (blink_in),
        .current_count(cnt),
        .offset_out   (offset_out),
        .offset_valid (offset_valid),
        .period_out   (period_out),
        .err          (err)
    );

    // Remote blinker: bit 9 of (count + offset), or a 500-cycle high pulse at the same period.
    function automatic logic raw(input logic [15:0] c);
        logic [15:0] s;
        s = c + off;
        return duty ? (s[9:0] < 10'd500) : s[9];
    endfunction

    task automatic tick();
        logic old;
        @(posedge clk);
        #1;
        cnt = cnt + 1'b1;
        old = blink_in;
        blink_in = stuck | (en & raw(cnt));
        rose = blink_in & ~old;
        err_seen = err_seen + (err ? 1 : 0);
        valid_seen = valid_seen + (offset_valid ? 1 : 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (count=%0h)", name, act, exp, cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        stuck = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic enable();
        for (int i = 0; i < 2 * P && !en; i++) begin
            tick();
            if (!raw(cnt)) en = 1'b1;
        end
    endtask

    task automatic wait_rise(output logic [15:0] c1);
        bit got;
        got = 1'b0;
        c1 = cnt;
        for (int i = 0; i < 3 * P && !got; i++) begin
            tick();
            if (rose) begin
                got = 1'b1;
                c1 = cnt;
            end
        end
        chk("line_rise_seen", 32'(got), 32'd1);
    endtask

    task automatic advance_to(input logic [15:0] t);
        for (int i = 0; i < 6 * P && cnt != t; i++) tick();
        chk("advance_bound", 32'(cnt), 32'(t));
    endtask

    task automatic wait_phase(input logic [9:0] ph);
        for (int i = 0; i < 2 * P && cnt[9:0] != ph; i++) tick();
    endtask

    // DUT sees the line rise 2 cycles late; lock shows one cycle after 4 further periods.
    task automatic expect_lock(input string name, input logic [15:0] c1, input logic [15:0] exp_off);
        advance_to(c1 + 16'(2 + 4 * P));
        chk({name, "_not_early"}, 32'(offset_valid), 32'd0);
        tick();
        chk({name, "_valid"}, 32'(offset_valid), 32'd1);
        chk({name, "_offset"}, 32'(offset_out), 32'(exp_off));
        chk({name, "_period"}, 32'(period_out), 32'd1024);
    endtask

    initial begin
        logic [15:0] c1, d;
        vecs[0] = '{16'h0123, 1'b0, 16'h0123, 16'd1024, 1'b1};
        vecs[1] = '{16'h8123, 1'b0, 16'h0123, 16'd1024, 1'b1};
        vecs[2] = '{16'h03F0, 1'b0, 16'h03F0, 16'd1024, 1'b1};
        vecs[3] = '{16'h0040, 1'b1, 16'h0000, 16'd1024, 1'b0};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            chk("rst_offset", 32'(offset_out), 32'd0);
            chk("rst_valid", 32'(offset_valid), 32'd0);
            chk("rst_period", 32'(period_out), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            off = vecs[v].off;
            duty = vecs[v].duty;
            enable();
            wait_rise(c1);
            err_seen = 0;
            valid_seen = 0;
            if (vecs[v].exp_lock) begin
                expect_lock("vec_lock", c1, vecs[v].exp_off);
                chk("vec_no_err", 32'(err_seen), 32'd0);
            end else begin
                repeat (6 * P) tick();
                chk("duty_never_valid", 32'(valid_seen), 32'd0);
                chk("duty_no_err", 32'(err_seen), 32'd0);
                chk("duty_period", 32'(period_out), 32'(vecs[v].exp_per));
            end
        end

        // Lock at 0x0123, then jump to 0x0200 while both waveforms are low.
        do_reset();
        off = 16'h0123;
        duty = 1'b0;
        enable();
        wait_rise(c1);
        expect_lock("pre_jump", c1, 16'h0123);
        wait_phase(10'd800);
        off = 16'h0200;
        err_seen = 0;
        wait_rise(c1);
        advance_to(c1 + 16'd2);
        chk("jump_err_before", 32'(err), 32'd0);
        chk("jump_valid_before", 32'(offset_valid), 32'd1);
        tick();
        chk("jump_err_pulse", 32'(err), 32'd1);
        chk("jump_valid_drop", 32'(offset_valid), 32'd0);
        tick();
        chk("jump_err_one_cycle", 32'(err), 32'd0);
        expect_lock("relock_jump", c1, 16'h0200);
        chk("jump_err_count", 32'(err_seen), 32'd1);

        // Stick the line high mid high-time; last DUT rise was at phase 2.
        wait_phase(10'd100);
        stuck = 1'b1;
        d = cnt - 16'd98;
        err_seen = 0;
        advance_to(d + 16'(2 * P + 1));
        chk("stuck_err_early", 32'(err), 32'd0);
        chk("stuck_valid_held", 32'(offset_valid), 32'd1);
        tick();
        chk("stuck_err_pulse", 32'(err), 32'd1);
        chk("stuck_valid_drop", 32'(offset_valid), 32'd0);
        tick();
        chk("stuck_err_one_cycle", 32'(err), 32'd0);
        chk("stuck_err_count", 32'(err_seen), 32'd1);

        // Release while the model is high, then relock from IDLE.
        wait_phase(10'd200);
        stuck = 1'b0;
        wait_rise(c1);
        expect_lock("relock_stuck", c1, 16'h0200);

        // One-cycle reset while locked, during the low half.
        wait_phase(10'd600);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_offset", 32'(offset_out), 32'd0);
        chk("midrst_valid", 32'(offset_valid), 32'd0);
        chk("midrst_period", 32'(period_out), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        wait_rise(c1);
        expect_lock("relock_rst", c1, 16'h0200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_phase_decoder.md
# blink_phase_decoder

Receive-side counterpart of the blinker. It samples an asynchronous blink line that some blinker drives from bit `TAP` of `(count + offset)`, where count is the shared free-running counter. It recovers the observable low bits of that offset and the blink period, and reports lock once the phase has been stable for several periods. It sits beside the blinker and reuses the same `current_count` bus, which increments by 1 every `clk`.

## Interface

**Parameters**
- `COUNT_W`, 16: width of the count and offset buses.
- `TAP`, 9: count bit the remote blinker outputs. Blink period is P = 2^(TAP+1) cycles; high time is H = 2^TAP cycles.
- `SYNC_STAGES`, 2: synchronizer depth on `blink_in` (≥2).
- `LOCK_EDGES`, 4: consecutive matching periods required for lock.

**Ports**
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: the clock.
  - `rst`, input, 1: synchronous, active-high reset.
- `blink_in`, input, 1: asynchronous blink line.
- `current_count`, input, COUNT_W: shared free-running counter.
- `offset_out`, output, COUNT_W: recovered offset. Bits [COUNT_W-1:TAP+1] are always 0.
- `offset_valid`, output, 1: high while in LOCKED.
- `period_out`, output, COUNT_W: last measured rise-to-rise interval, saturating.
- `err`, output, 1: one-cycle pulse on loss of lock or timeout.

## Operation

**Front end**
- `blink_in` passes through `SYNC_STAGES` flops; `s_prev` is the synchronizer output delayed by one cycle.
- `rise` = sync & ~s_prev; `fall` = ~sync & s_prev.

**Phase estimate**
- Computed on each `rise`: `cand` = (H + SYNC_STAGES − `current_count`) mod P, zero-extended to COUNT_W.
- This gives `offset` mod P exactly when the remote counter matches `current_count`.

**Counters**
- `per_cnt` counts cycles since the last `rise`, saturating at all-ones.
- `hi_cnt` counts cycles since the last `rise` while the synchronized line is high.

**A period "matches" on a `rise` when all of the following hold:**
- `per_cnt`+1 == P;
- the high time captured at the preceding `fall` == H;
- `cand` == `phase_reg`.

**States**
- **IDLE** (reset state):
  - First `rise` → MEASURE; `phase_reg`←`cand`; `match_cnt`←0.
- **MEASURE**:
  - `rise` with a match: `match_cnt`++. When it reaches LOCK_EDGES → LOCKED, and `offset_out`←`phase_reg`.
  - `rise` without a match: `phase_reg`←`cand`, `match_cnt`←0, stay in MEASURE, no `err`.
  - `per_cnt` ≥ 2P with no edge → IDLE and `err` pulse.
- **LOCKED**:
  - `rise` with a match: stay; `offset_out` is unchanged.
  - `rise` without a match: `err` pulse, `offset_valid` drops, → MEASURE, with `phase_reg`←`cand` and `match_cnt`←0.
  - `per_cnt` ≥ 2P with no edge → IDLE and `err` pulse.

**Other rules**
- `period_out` ← `per_cnt`+1, saturating, on every `rise` in MEASURE or LOCKED.
- Simultaneous events: `rst` beats everything; `rise` beats timeout in the same cycle.
- `rst` mid-lock returns the block to IDLE on the next edge.
- Reset values: `offset_out`=0, `offset_valid`=0, `period_out`=0, `err`=0. State is IDLE and all counters are 0.

## Timing

- A transition of `blink_in` during the cycle where `current_count`=c is seen as `rise`/`fall` in the cycle where `current_count` = c+SYNC_STAGES.
- All outputs are registered and update on the clock edge that ends the cycle in which `rise` is asserted.
- `err` is high for exactly one cycle.
- Minimum lock time from the first `rise` is LOCK_EDGES·P cycles.
- No combinational path from any input to any output.

## Structure

- Package `blink_pkg`:
  - state encoding (IDLE/MEASURE/LOCKED);
  - localparam helpers for P, H, and the timeout 2P.
- One sub-module, `blink_sync_edge`:
  - contains the `SYNC_STAGES` synchronizer, `s_prev`, and the `rise`/`fall` outputs;
  - reused by any future blink receiver.

## Test plan

1. **Lock.** Drive `blink_in` from a blinker model with offset 0x0123 and default parameters.
   - `offset_valid` rises 4·1024 cycles after the first `rise`.
   - `offset_out`=0x0123 and `period_out`=1024.
2. **Unobservable bits.** Use offset 0x8123.
   - `offset_out`=0x0123 (bit 15 not recoverable); `offset_valid`=1.
3. **Phase jump.** While locked, step the offset to 0x0200.
   - One `err` pulse and `offset_valid`=0 at the next `rise`.
   - Relock with `offset_out`=0x0200 after 4 further periods.
4. **Stuck line.** While locked, hold `blink_in`=1.
   - `err` pulse and state IDLE exactly 2048 cycles after the last `rise`; `offset_valid`=0.
5. **Bad duty cycle.** Use a period of 1024 with high time 500.
   - `offset_valid` never asserts and `err` stays 0.
6. **Reset mid-lock.** Assert `rst` for 1 cycle while locked.
   - All outputs are 0 the next cycle.
   - Relock after the first `rise` plus 4 periods.
